vga_pixel_fetch: RTL and testbench

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/vga_delay_line.sv | 37 +++
 rtl/vga_pixel_fetch.sv | 166 ++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ============================================================================
// Module  : vga_pkg
// Brief   : Shared VGA framebuffer geometry defaults and RGB332 colour helpers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_pkg;

   localparam int c_H_START = 145;
   localparam int c_V_START = 36;
   localparam int c_FB_W    = 160;
   localparam int c_FB_H    = 120;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   localparam rgb888_t c_RGB_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
   localparam rgb888_t c_RGB_WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};

   // Bit replication keeps full-scale codes at 8'hFF and zero at 8'h00.
   function automatic rgb888_t rgb332_to_rgb888(input rgb332_t c);
      rgb888_t o;
      o.r = {c.r, c.r, c.r[2:1]};
      o.g = {c.g, c.g, c.g[2:1]};
      o.b = {c.b, c.b, c.b, c.b};
      return o;
   endfunction

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
// ============================================================================
// Module  : vga_delay_line
// Brief   : Resettable shift pipeline of configurable depth and width.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_delay_line #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 1
) (
   input  logic             VGA_CLK_IN,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_pipe [DEPTH];

   always_ff @(posedge VGA_CLK_IN or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_pipe[i] <= '0;
         end
      end else begin
         r_pipe[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign q = r_pipe[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_pixel_fetch.sv
// ============================================================================
// Module  : vga_pixel_fetch
// Brief   : Maps VGA raster counters to scaled framebuffer reads and drives
//           RGB888 plus delay-matched sync. Optional macro PIXEL_FETCH_GRID_EN
//           overlays a white grid every 16 framebuffer words.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_pixel_fetch
   import vga_pkg::*;
#(
   parameter int H_START  = c_H_START,
   parameter int V_START  = c_V_START,
   parameter int FB_W     = c_FB_W,
   parameter int FB_H     = c_FB_H,
   parameter int SCALE_SH = 2,
   parameter int MEM_LAT  = 1
) (
   input  logic        VGA_CLK_IN,
   input  logic        reset,
   input  logic        video_on,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   output logic [14:0] mem_addr,
   output logic        mem_rd_en,
   input  logic [7:0]  mem_rdata,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_N,
   output logic        VGA_SYNC_N
);

   localparam logic [9:0] c_H_OFF   = 10'(H_START);
   localparam logic [9:0] c_V_OFF   = 10'(V_START);
   localparam logic [9:0] c_COL_MAX = 10'(FB_W - 1);
   localparam logic [9:0] c_ROW_MAX = 10'(FB_H - 1);

   // Constant multiply by FB_W as a sum of shifted copies of row.
   function automatic logic [14:0] row_times_fbw(input logic [9:0] row);
      logic [14:0] acc;
      acc = '0;
      for (int i = 0; i < 15; i++) begin
         if (((FB_W >> i) & 1) != 0) begin
            acc = acc + ({5'd0, row} << i);
         end
      end
      return acc;
   endfunction

   logic [9:0]  w_dx;
   logic [9:0]  w_dy;
   logic [9:0]  w_col_raw;
   logic [9:0]  w_row_raw;
   logic [9:0]  w_col;
   logic [9:0]  w_row;
   logic [14:0] w_addr;

   // Counters left of/above the visible origin wrap to large values and clamp.
   always_comb begin
      w_dx      = pixel_x - c_H_OFF;
      w_dy      = pixel_y - c_V_OFF;
      w_col_raw = w_dx >> SCALE_SH;
      w_row_raw = w_dy >> SCALE_SH;
      w_col     = (w_col_raw > c_COL_MAX) ? c_COL_MAX : w_col_raw;
      w_row     = (w_row_raw > c_ROW_MAX) ? c_ROW_MAX : w_row_raw;
      w_addr    = row_times_fbw(w_row) + {5'd0, w_col};
   end

   logic [14:0] r_mem_addr;
   logic        r_mem_rd_en;

   always_ff @(posedge VGA_CLK_IN or posedge reset) begin
      if (reset) begin
         r_mem_addr  <= '0;
         r_mem_rd_en <= 1'b0;
      end else begin
         r_mem_rd_en <= video_on;
         if (video_on) begin
            r_mem_addr <= w_addr;
         end
      end
   end

   assign mem_addr  = r_mem_addr;
   assign mem_rd_en = r_mem_rd_en;

   // Sync/video_on aligned with mem_rdata; the output register adds the last stage.
   logic [2:0] w_sync_al;

   vga_delay_line #(
      .DEPTH (MEM_LAT + 1),
      .WIDTH (3)
   ) u_sync_dly (
      .VGA_CLK_IN (VGA_CLK_IN),
      .reset      (reset),
      .d          ({video_on, hsync, vsync}),
      .q          (w_sync_al)
   );

   rgb888_t w_pix;

`ifdef PIXEL_FETCH_GRID_EN
   logic [7:0] r_grid_a;
   logic [7:0] w_grid_al;
   logic       w_grid_hit;

   always_ff @(posedge VGA_CLK_IN or posedge reset) begin
      if (reset) begin
         r_grid_a <= '0;
      end else begin
         r_grid_a <= {w_col[3:0], w_row[3:0]};
      end
   end

   vga_delay_line #(
      .DEPTH (MEM_LAT),
      .WIDTH (8)
   ) u_grid_dly (
      .VGA_CLK_IN (VGA_CLK_IN),
      .reset      (reset),
      .d          (r_grid_a),
      .q          (w_grid_al)
   );

   assign w_grid_hit = (w_grid_al[7:4] == 4'd0) || (w_grid_al[3:0] == 4'd0);
   assign w_pix      = w_grid_hit ? c_RGB_WHITE : rgb332_to_rgb888(rgb332_t'(mem_rdata));
`else
   assign w_pix = rgb332_to_rgb888(rgb332_t'(mem_rdata));
`endif

   rgb888_t r_rgb;
   logic    r_hs;
   logic    r_vs;
   logic    r_blank_n;

   always_ff @(posedge VGA_CLK_IN or posedge reset) begin
      if (reset) begin
         r_rgb     <= c_RGB_BLACK;
         r_hs      <= 1'b0;
         r_vs      <= 1'b0;
         r_blank_n <= 1'b0;
      end else begin
         r_rgb     <= w_sync_al[2] ? w_pix : c_RGB_BLACK;
         r_hs      <= w_sync_al[1];
         r_vs      <= w_sync_al[0];
         r_blank_n <= w_sync_al[2];
      end
   end

   assign VGA_R       = r_rgb.r;
   assign VGA_G       = r_rgb.g;
   assign VGA_B       = r_rgb.b;
   assign VGA_HS      = r_hs;
   assign VGA_VS      = r_vs;
   assign VGA_BLANK_N = r_blank_n;
   assign VGA_SYNC_N  = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
// ============================================================================
// Module  : tb_vga_pixel_fetch
// Brief   : Randomized raster stimulus against an arithmetic reference model,
//           two DUT instances with read latencies 1 and 3.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_pixel_fetch;

   localparam int c_N      = 3000;
   localparam int c_FB_SZ  = 19200;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       video_on = 1'b0;
   logic       hsync = 1'b0;
   logic       vsync = 1'b0;
   logic [9:0] pixel_x = '0;
   logic [9:0] pixel_y = '0;

   logic [14:0] addr1, addr3;
   logic        en1, en3;
   logic [7:0]  rdata1, rdata3;
   logic [7:0]  r1, g1, b1, r3, g3, b3;
   logic        hs1, vs1, bn1, sn1, hs3, vs3, bn3, sn3;

   always #20 clk = ~clk;

   vga_pixel_fetch #(.MEM_LAT(1)) u_dut_l1 (
      .VGA_CLK_IN (clk), .reset (reset), .video_on (video_on),
      .hsync (hsync), .vsync (vsync), .pixel_x (pixel_x), .pixel_y (pixel_y),
      .mem_addr (addr1), .mem_rd_en (en1), .mem_rdata (rdata1),
      .VGA_R (r1), .VGA_G (g1), .VGA_B (b1), .VGA_HS (hs1), .VGA_VS (vs1),
      .VGA_BLANK_N (bn1), .VGA_SYNC_N (sn1)
   );

   vga_pixel_fetch #(.MEM_LAT(3)) u_dut_l3 (
      .VGA_CLK_IN (clk), .reset (reset), .video_on (video_on),
      .hsync (hsync), .vsync (vsync), .pixel_x (pixel_x), .pixel_y (pixel_y),
      .mem_addr (addr3), .mem_rd_en (en3), .mem_rdata (rdata3),
      .VGA_R (r3), .VGA_G (g3), .VGA_B (b3), .VGA_HS (hs3), .VGA_VS (vs3),
      .VGA_BLANK_N (bn3), .VGA_SYNC_N (sn3)
   );

   // Framebuffer contents and synchronous read models.
   logic [7:0] fb [c_FB_SZ];
   logic [7:0] rd3_p [3];

   function automatic logic [7:0] fb_rd(input logic [14:0] a);
      return (int'(a) < c_FB_SZ) ? fb[a] : 8'h00;
   endfunction

   always @(posedge clk) begin
      rdata1   <= fb_rd(addr1);
      rd3_p[0] <= fb_rd(addr3);
      rd3_p[1] <= rd3_p[0];
      rd3_p[2] <= rd3_p[1];
   end
   assign rdata3 = rd3_p[2];

   // Stimulus tables.
   int sx [c_N];
   int sy [c_N];
   bit sv [c_N];
   bit shs [c_N];
   bit svs [c_N];
   bit srst [c_N];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int ref_col(input int x);
      int c;
      c = ((x - 145) & 1023) / 4;
      return (c > 159) ? 159 : c;
   endfunction

   function automatic int ref_row(input int y);
      int r;
      r = ((y - 36) & 1023) / 4;
      return (r > 119) ? 119 : r;
   endfunction

   function automatic int ref_addr(input int x, input int y);
      return ref_row(y) * 160 + ref_col(x);
   endfunction

   function automatic int ref_rgb(input int d);
      int rr, gg, bb;
      rr = d / 32;
      gg = (d / 4) % 8;
      bb = d % 4;
      return (((rr * 32) + (rr * 4) + (rr / 2)) * 65536)
           + (((gg * 32) + (gg * 4) + (gg / 2)) * 256)
           + (bb * 85);
   endfunction

   task automatic check_out(input int c, input int lat, input string pfx,
                            input logic [23:0] rgb, input logic bn,
                            input logic hs, input logic vs, input logic sn);
      bit ok;
      int k;
      int e_rgb;
      bit e_v, e_hs, e_vs;
      ok = (c >= lat + 2);
      for (int j = c - lat - 2; j <= c; j++) begin
         if (j >= 0 && srst[j]) ok = 1'b0;
      end
      e_rgb = 0; e_v = 0; e_hs = 0; e_vs = 0;
      if (ok) begin
         k    = c - lat - 2;
         e_v  = sv[k];
         e_hs = shs[k];
         e_vs = svs[k];
         if (e_v) begin
`ifdef PIXEL_FETCH_GRID_EN
            if ((ref_col(sx[k]) % 16 == 0) || (ref_row(sy[k]) % 16 == 0))
               e_rgb = 32'hFFFFFF;
            else
               e_rgb = ref_rgb(int'(fb[ref_addr(sx[k], sy[k])]));
`else
            e_rgb = ref_rgb(int'(fb[ref_addr(sx[k], sy[k])]));
`endif
         end
      end
      check({pfx, "_rgb"},     {8'h00, rgb}, e_rgb);
      check({pfx, "_blank_n"}, {31'd0, bn},  {31'd0, e_v});
      check({pfx, "_hs"},      {31'd0, hs},  {31'd0, e_hs});
      check({pfx, "_vs"},      {31'd0, vs},  {31'd0, e_vs});
      check({pfx, "_sync_n"},  {31'd0, sn},  32'd0);
   endtask

   int  m_addr;
   bit  m_en;

   initial begin
      for (int i = 0; i < c_FB_SZ; i++) fb[i] = 8'($urandom);
      fb[0]     = 8'hE0;
      fb[2573]  = 8'hE0;
      fb[19199] = 8'h1F;

      for (int c = 0; c < c_N; c++) begin
         srst[c] = (c < 3);
         if ($urandom_range(0, 9) < 7) begin
            sx[c] = $urandom_range(145, 784);
            sy[c] = $urandom_range(36, 515);
            sv[c] = 1'b1;
         end else begin
            sx[c] = $urandom_range(0, 799);
            sy[c] = $urandom_range(0, 524);
            sv[c] = 1'($urandom_range(0, 1));
         end
         shs[c] = ($urandom_range(0, 7) == 0);
         svs[c] = ($urandom_range(0, 15) == 0);
      end
      // Boundary points and the hold-while-blank window.
      sx[3] = 145; sy[3] = 36;  sv[3] = 1'b1;
      sx[4] = 783; sy[4] = 515; sv[4] = 1'b1;
      sx[5] = 200; sy[5] = 100; sv[5] = 1'b1;
      for (int c = 6; c < 11; c++) sv[c] = 1'b0;
      sx[11] = 144; sy[11] = 35; sv[11] = 1'b1;
      sx[12] = 799; sy[12] = 525; sv[12] = 1'b1;
      // A 95-cycle hsync pulse in a blanking stretch.
      for (int c = 20; c < 130; c++) begin
         sx[c]  = 640 + (c - 20);
         sy[c]  = 200;
         sv[c]  = 1'b0;
         shs[c] = (c < 115);
         svs[c] = 1'b0;
      end
      // Mid-line resets.
      sx[1499] = 400; sy[1499] = 200; sv[1499] = 1'b1;
      sx[1500] = 400; srst[1500] = 1'b1;
      srst[1501] = 1'b1;
      srst[2500] = 1'b1;

      m_addr = 0;
      m_en   = 1'b0;
      for (int c = 0; c < c_N; c++) begin
         @(posedge clk);
         #1;
         reset    = srst[c];
         pixel_x  = 10'(sx[c]);
         pixel_y  = 10'(sy[c]);
         video_on = sv[c];
         hsync    = shs[c];
         vsync    = svs[c];
         @(negedge clk);
         cyc = c;
         if (srst[c]) begin
            m_addr = 0;
            m_en   = 1'b0;
         end else if (c > 0 && !srst[c-1]) begin
            m_en = sv[c-1];
            if (sv[c-1]) m_addr = ref_addr(sx[c-1], sy[c-1]);
         end
         check("l1_addr",  {17'd0, addr1}, m_addr);
         check("l1_rd_en", {31'd0, en1},   {31'd0, m_en});
         check("l3_addr",  {17'd0, addr3}, m_addr);
         check("l3_rd_en", {31'd0, en3},   {31'd0, m_en});
         check_out(c, 1, "l1", {r1, g1, b1}, bn1, hs1, vs1, sn1);
         check_out(c, 3, "l3", {r3, g3, b3}, bn3, hs3, vs3, sn3);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
